// File: rtl/fpu_arith_issue_ctrl.sv
// Issue/retire sequencer for FPU_ArithmeticUnit: one request in, one response out, sticky flags.
// Optional watchdog abort in WAIT enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_arith_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_rnd,
  input  logic [79:0] req_a,
  input  logic [79:0] req_b,
  output logic [3:0]  au_operation,
  output logic        au_enable,
  output logic [1:0]  au_rounding_mode,
  output logic [79:0] au_operand_a,
  output logic [79:0] au_operand_b,
  output logic [15:0] au_int16_in,
  output logic [31:0] au_int32_in,
  output logic [31:0] au_fp32_in,
  output logic [63:0] au_fp64_in,
  input  logic [79:0] au_result,
  input  logic [15:0] au_int16_out,
  input  logic [31:0] au_int32_out,
  input  logic [31:0] au_fp32_out,
  input  logic [63:0] au_fp64_out,
  input  logic        au_done,
  input  logic [3:0]  au_cc,
  input  logic [5:0]  au_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [79:0] rsp_data,
  output logic [3:0]  rsp_cc,
  output logic [5:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic [5:0]  sticky_flags,
  input  logic        sticky_clear,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_op;
  logic [1:0]  r_rnd;
  logic [79:0] r_a, r_b;
  logic [79:0] r_rsp_data;
  logic [3:0]  r_rsp_cc;
  logic [5:0]  r_rsp_flags;
  logic [5:0]  r_sticky;

  logic        w_accept, w_illegal, w_done_cap, w_abort, w_load;
  logic [79:0] w_sel_data;
  logic [5:0]  w_new_flags;

  assign req_ready  = reset & (r_state == S_IDLE);
  assign w_accept   = req_valid & req_ready;
  assign w_illegal  = w_accept & (req_op > 4'd11);
  assign w_done_cap = (r_state == S_WAIT) & au_done;
  assign w_load     = w_illegal | w_done_cap | w_abort;
  // Only a genuine unit completion reports the unit's flags; both abort paths report invalid.
  assign w_new_flags = w_done_cap ? au_flags : 6'b000001;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt;
  logic       r_rsp_timeout;

  assign w_abort     = (r_state == S_WAIT) & ~au_done & (r_wait_cnt == LP_TO_LAST);
  assign rsp_timeout = r_rsp_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_load) r_rsp_timeout <= w_abort;
    end
  end
`else
  assign w_abort     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done_cap || w_abort) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_op)
      4'd6:    w_sel_data = {{64{au_int16_out[15]}}, au_int16_out};
      4'd7:    w_sel_data = {{48{au_int32_out[31]}}, au_int32_out};
      4'd10:   w_sel_data = {48'b0, au_fp32_out};
      4'd11:   w_sel_data = {16'b0, au_fp64_out};
      default: w_sel_data = au_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op  <= '0;
      r_rnd <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_op  <= req_op;
      r_rnd <= req_rnd;
      r_a   <= req_a;
      r_b   <= req_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_data  <= '0;
      r_rsp_cc    <= '0;
      r_rsp_flags <= '0;
      r_sticky    <= '0;
    end else begin
      if (w_load) begin
        r_rsp_data  <= w_done_cap ? w_sel_data : '0;
        r_rsp_cc    <= w_done_cap ? au_cc : '0;
        r_rsp_flags <= w_new_flags;
        // A clear coinciding with a capture drops the old history but keeps the new flags.
        r_sticky    <= (sticky_clear ? '0 : r_sticky) | w_new_flags;
      end else if (sticky_clear) begin
        r_sticky <= '0;
      end
    end
  end

  assign au_operation     = r_op;
  assign au_rounding_mode = r_rnd;
  assign au_operand_a     = r_a;
  assign au_operand_b     = r_b;
  assign au_int16_in      = r_a[15:0];
  assign au_int32_in      = r_a[31:0];
  assign au_fp32_in       = r_a[31:0];
  assign au_fp64_in       = r_a[63:0];
  assign au_enable        = (r_state == S_ISSUE);

  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_data     = r_rsp_data;
  assign rsp_cc       = r_rsp_cc;
  assign rsp_flags    = r_rsp_flags;
  assign sticky_flags = r_sticky;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_arith_issue_ctrl.sv
// Self-checking bench for fpu_arith_issue_ctrl: emulated arithmetic unit plus a transaction-level model.
// Define FPU_ISSUE_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_fpu_arith_issue_ctrl;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_rnd;
  logic [79:0] req_a, req_b;
  logic [3:0]  au_operation;
  logic        au_enable;
  logic [1:0]  au_rounding_mode;
  logic [79:0] au_operand_a, au_operand_b;
  logic [15:0] au_int16_in;
  logic [31:0] au_int32_in, au_fp32_in;
  logic [63:0] au_fp64_in;
  logic [79:0] au_result;
  logic [15:0] au_int16_out;
  logic [31:0] au_int32_out, au_fp32_out;
  logic [63:0] au_fp64_out;
  logic        au_done;
  logic [3:0]  au_cc;
  logic [5:0]  au_flags;
  logic        rsp_valid, rsp_ready;
  logic [79:0] rsp_data;
  logic [3:0]  rsp_cc;
  logic [5:0]  rsp_flags;
  logic        rsp_timeout;
  logic [5:0]  sticky_flags;
  logic        sticky_clear;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [5:0]  model_sticky = '0;
  logic        tb_clr = 1'b0;
  logic        u_clr_pulse = 1'b0;
  int          u_n = 1;
  bit          u_early = 1'b0;
  bit          u_clr = 1'b0;
  int          u_cnt = 0;

  assign sticky_clear = tb_clr | u_clr_pulse;

  fpu_arith_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rnd(req_rnd),
    .req_a(req_a), .req_b(req_b),
    .au_operation(au_operation), .au_enable(au_enable), .au_rounding_mode(au_rounding_mode),
    .au_operand_a(au_operand_a), .au_operand_b(au_operand_b),
    .au_int16_in(au_int16_in), .au_int32_in(au_int32_in), .au_fp32_in(au_fp32_in),
    .au_fp64_in(au_fp64_in), .au_result(au_result), .au_int16_out(au_int16_out),
    .au_int32_out(au_int32_out), .au_fp32_out(au_fp32_out), .au_fp64_out(au_fp64_out),
    .au_done(au_done), .au_cc(au_cc), .au_flags(au_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cc(rsp_cc),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .sticky_flags(sticky_flags),
    .sticky_clear(sticky_clear), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Emulated unit: done pulses N cycles after the enable edge (u_n==0 means never).
  always @(negedge clk) begin
    au_done = 1'b0;
    u_clr_pulse = 1'b0;
    if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        au_done = 1'b1;
        u_clr_pulse = u_clr;
      end
    end
    if (au_enable) begin
      if (u_early) au_done = 1'b1;
      if (u_n > 0) u_cnt = u_n;
    end
  end

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [79:0] ref_data(input logic [3:0] op);
    logic signed [79:0] s;
    case (op)
      4'd6:    begin s = $signed(au_int16_out); return s; end
      4'd7:    begin s = $signed(au_int32_out); return s; end
      4'd10:   return 80'(au_fp32_out);
      4'd11:   return 80'(au_fp64_out);
      default: return au_result;
    endcase
  endfunction

  function automatic void randomize_unit();
    au_result    = rand80();
    au_int16_out = 16'($urandom);
    au_int32_out = $urandom;
    au_fp32_out  = $urandom;
    au_fp64_out  = {$urandom, $urandom};
    au_cc        = 4'($urandom);
    au_flags     = 6'($urandom);
  endfunction

  // One full transaction; unit outputs must be set by the caller beforehand. n==0: unit never finishes.
  task automatic do_op(input logic [3:0] op, input logic [1:0] rnd, input logic [79:0] a,
                       input logic [79:0] b, input int n, input bit early, input bit clr,
                       input int hold);
    logic [79:0] exp_data;
    logic [3:0]  exp_cc;
    logic [5:0]  exp_flags;
    bit          exp_to;
    int          lat, t_acc, en_cnt;
    bit          got;
    if (op > 4'd11) begin
      exp_data = '0; exp_cc = '0; exp_flags = 6'b000001; exp_to = 0; lat = 0;
    end else if (n == 0) begin
      exp_data = '0; exp_cc = '0; exp_flags = 6'b000001; exp_to = 1; lat = 1 + TO;
    end else begin
      exp_data = ref_data(op); exp_cc = au_cc; exp_flags = au_flags; exp_to = 0; lat = 1 + n;
    end
    model_sticky = ((clr && n > 0 && op <= 4'd11) ? 6'b0 : model_sticky) | exp_flags;
    u_n = n; u_early = early; u_clr = clr;

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_req: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_rnd = rnd; req_a = a; req_b = b;
    @(negedge clk);
    t_acc = cyc;
    req_valid = 1'b0; req_op = 4'($urandom); req_rnd = 2'($urandom);
    req_a = rand80(); req_b = rand80();
    en_cnt = 0; got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (au_enable) en_cnt++;
      if (rsp_valid) got = 1;
      else begin
        checks++;
        if ({au_operation, au_rounding_mode, au_operand_a, au_operand_b, au_int16_in, au_int32_in,
             au_fp32_in, au_fp64_in} !== {op, rnd, a, b, a[15:0], a[31:0], a[31:0], a[63:0]}) begin
          errors++; $display("FAIL au_hold: got op %h a %h expected op %h a %h", au_operation,
                             au_operand_a, op, a);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL rsp_wait: got no rsp_valid expected one within 400 cycles");
      return;
    end
    checks++;
    if (cyc - t_acc !== lat) begin
      errors++; $display("FAIL latency op %0d: got %0d expected %0d", op, cyc - t_acc, lat);
    end
    checks++;
    if (en_cnt !== ((op <= 4'd11) ? 1 : 0)) begin
      errors++; $display("FAIL enable_pulses op %0d: got %0d expected %0d", op, en_cnt,
                         (op <= 4'd11) ? 1 : 0);
    end
    checks++;
    if ({rsp_data, rsp_cc, rsp_flags, rsp_timeout} !== {exp_data, exp_cc, exp_flags, exp_to}) begin
      errors++; $display("FAIL rsp op %0d: got %h/%h/%b/%b expected %h/%h/%b/%b", op, rsp_data,
                         rsp_cc, rsp_flags, rsp_timeout, exp_data, exp_cc, exp_flags, exp_to);
    end
    checks++;
    if (sticky_flags !== model_sticky) begin
      errors++; $display("FAIL sticky op %0d: got %b expected %b", op, sticky_flags, model_sticky);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 4'($urandom_range(0, 11));
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, au_enable, rsp_data, rsp_flags, au_operation, au_operand_a} !==
          {1'b1, 1'b0, 1'b0, exp_data, exp_flags, op, a}) begin
        errors++; $display("FAIL backpressure: got v%b r%b data %h expected v1 r0 data %h",
                           rsp_valid, req_ready, rsp_data, exp_data);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL retire: got v%b r%b busy%b expected v0 r1 busy0", rsp_valid,
                         req_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_op = 4'd0; req_rnd = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; randomize_unit();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, au_enable, rsp_valid, busy, rsp_timeout, sticky_flags, rsp_data, rsp_cc,
         rsp_flags, au_operation, au_operand_a, au_operand_b} !== '0) begin
      errors++; $display("FAIL reset_state: got ready %b busy %b rsp %h expected all zero",
                         req_ready, busy, rsp_data);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL after_reset: got r%b busy%b expected r1 busy0", req_ready, busy);
    end
  endtask

  task automatic test_add();
    au_result = 80'h4000_C000000000000000; au_cc = 4'b0000; au_flags = '0;
    do_op(4'd0, 2'd0, 80'h3FFF_8000000000000000, 80'h4000_8000000000000000, 3, 0, 0, 0);
  endtask

  task automatic test_fp_to_i16();
    randomize_unit(); au_int16_out = 16'hFFFD;
    do_op(4'd6, 2'd3, 80'hC000_C000000000000000, rand80(), 2, 0, 0, 0);
  endtask

  task automatic test_early_done();
    randomize_unit(); au_int32_out = 32'h8000_0001;
    do_op(4'd7, 2'd1, rand80(), rand80(), 2, 1, 0, 1);
    randomize_unit();
    do_op(4'd10, 2'd2, rand80(), rand80(), 1, 1, 0, 0);
    randomize_unit();
    do_op(4'd11, 2'd0, rand80(), rand80(), 4, 0, 0, 0);
  endtask

  task automatic test_sticky();
    @(negedge clk); tb_clr = 1'b1;
    @(negedge clk); tb_clr = 1'b0;
    model_sticky = '0;
    checks++;
    if (sticky_flags !== 6'b0) begin
      errors++; $display("FAIL sticky_clear: got %b expected 000000", sticky_flags);
    end
    randomize_unit(); au_flags = 6'b000100;
    do_op(4'd3, 2'd0, rand80(), rand80(), 2, 0, 0, 0);
    randomize_unit(); au_flags = 6'b100000;
    do_op(4'd2, 2'd0, rand80(), rand80(), 2, 0, 0, 0);
    checks++;
    if (sticky_flags !== 6'b100100) begin
      errors++; $display("FAIL sticky_accum: got %b expected 100100", sticky_flags);
    end
    randomize_unit(); au_flags = 6'b100000;
    do_op(4'd2, 2'd0, rand80(), rand80(), 3, 0, 1, 0);
    checks++;
    if (sticky_flags !== 6'b100000) begin
      errors++; $display("FAIL sticky_clear_on_capture: got %b expected 100000", sticky_flags);
    end
  endtask

  task automatic test_illegal_op();
    randomize_unit();
    do_op(4'd13, 2'd0, rand80(), rand80(), 1, 0, 0, 0);
    do_op(4'd15, 2'd2, rand80(), rand80(), 1, 0, 0, 2);
  endtask

  task automatic test_backpressure();
    randomize_unit();
    do_op(4'd0, 2'd1, rand80(), rand80(), 1, 0, 0, 10);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    au_flags = '0; u_n = 1; u_early = 0; u_clr = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd1; req_a = rand80(); req_b = rand80();
    for (int i = 0; i < 20; i++) begin
      if (req_ready) acc.push_back(cyc + 1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (acc.size() < 4) begin
      errors++; $display("FAIL b2b_count: got %0d accepts expected at least 4", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 4) begin
        errors++; $display("FAIL b2b_gap %0d: got %0d expected 4", i, acc[i] - acc[i-1]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int n;
      randomize_unit();
      n = $urandom_range(1, 4);
      do_op(4'($urandom_range(0, 15)), 2'($urandom), rand80(), rand80(), n,
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_op();
    randomize_unit();
    u_n = 3; u_early = 0; u_clr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd2; req_a = rand80(); req_b = rand80();
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_sticky = '0;
    #1;
    checks++;
    if ({busy, req_ready, rsp_valid, sticky_flags, au_operand_a} !== '0) begin
      errors++; $display("FAIL async_reset: got busy %b ready %b sticky %b expected zeros", busy,
                         req_ready, sticky_flags);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
        errors++; $display("FAIL late_done: got v%b busy%b r%b expected v0 busy0 r1", rsp_valid,
                           busy, req_ready);
      end
    end
  endtask

`ifdef FPU_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    randomize_unit();
    do_op(4'd3, 2'd0, rand80(), rand80(), 0, 0, 0, 1);
    checks++;
    if (sticky_flags[0] !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b expected invalid set", sticky_flags);
    end
  endtask
`endif

  initial begin
    au_done = 1'b0;
    test_reset();
    test_add();
    test_fp_to_i16();
    test_early_done();
    test_sticky();
    test_illegal_op();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef FPU_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
